addsub_rr_arbiter: RTL and testbench
====================================

// Module: addsub_rr_arbiter
// PURPOSE
//  Shares one 4-bit add/sub datapath (bit_4_addsub: S, C, V from A, B, M) between two requesters.
//  Each requester presents operands with a valid/ready handshake. A round-robin arbiter grants one
//  request per cycle. The result is held in a single output register with its own valid/ready
//  handshake. A saturating counter tracks signed overflows.
//  Sits between the operand sources and the ALU result consumer.
// PARAMETERS
//  INIT_PRIO   0   requester that has priority after reset (0 or 1)
//  RR_EN       1   1 = round-robin; 0 = fixed priority, INIT_PRIO always wins
//  OVF_W       8   width of the overflow counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous reset, active low
//  req0_valid  in   1      requester 0 operands valid
//  req0_ready  out  1      requester 0 accepted this cycle (grant)
//  req0_a      in   4      requester 0 operand A
//  req0_b      in   4      requester 0 operand B
//  req0_m      in   1      requester 0 mode: 0 = A+B, 1 = A-B
//  req1_*      ...         identical set for requester 1
//  res_valid   out  1      result register holds a valid result
//  res_ready   in   1      consumer accepts the result this cycle
//  res_id      out  1      index of the requester that produced the result
//  res_s       out  4      sum/difference
//  res_c       out  1      carry out (for subtract: 1 = no borrow)
//  res_v       out  1      signed overflow
//  ovf_cnt     out  OVF_W  count of accepted results with V=1; saturates at all-ones
//  ovf_clr     in   1      synchronous clear of ovf_cnt
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (rst_n); all state is clocked on clk.
//  Reset values: res_valid=0, res_id=0, res_s=0, res_c=0, res_v=0, ovf_cnt=0, prio=INIT_PRIO.
//  Output stage FSM, two states:
//   - EMPTY -> FULL on a grant.
//   - FULL -> EMPTY on res_ready when there is no grant.
//   - FULL stays FULL when res_ready and a grant occur in the same cycle (back-to-back).
//  can_accept = !res_valid | res_ready.
//  Grant logic (combinational):
//   - No grant if !can_accept.
//   - If exactly one reqN_valid is high, that requester wins.
//   - If both are high, the prio requester wins.
//   - reqN_ready is high only for the winner. reqN_ready may depend on reqN_valid; no comb path from res_* outputs.
//  Datapath: the winner's A, B, M drive a single shared bit_4_addsub instance.
//   - On the grant edge, S, C, V and the winner index are loaded into res_*.
//   - Latency: 1 cycle (grant at edge k -> res_valid=1 after edge k).
//  Round-robin (RR_EN=1): after any grant, prio <= the other requester. No grant -> prio unchanged.
//  Fixed priority (RR_EN=0): prio is fixed at INIT_PRIO.
//  Stall: while res_valid=1 and res_ready=0:
//   - res_* are held stable and both reqN_ready are 0.
//   - Requesters must hold their operands until ready.
//  ovf_cnt:
//   - Increments by 1 on each grant whose V=1, saturating at 2^OVF_W-1.
//   - ovf_clr sets it to 0 and takes precedence over a same-cycle increment.
//  Reset mid-operation: any pending result is discarded; no partial state survives.
// TESTING
//  Add: req0 A=5, B=3, M=0 alone -> next cycle res_valid=1, id=0, S=8, C=0, V=1, ovf_cnt=1.
//  Sub: req1 A=5, B=3, M=1 alone -> S=2, C=1, V=0, id=1; ovf_cnt unchanged.
//  Both valid every cycle, res_ready=1, RR_EN=1, INIT_PRIO=0 -> grants 0,1,0,1; one result per cycle.
//  res_ready=0 for 3 cycles with both valid -> res_* held, both ready=0; first release cycle grants next.
//  Edge values: A=8, B=1, M=1 -> S=7, C=1, V=1. A=F, B=1, M=0 -> S=0, C=1, V=0.
//  Saturation/reset: OVF_W=2, 5 overflows -> ovf_cnt=3; ovf_clr -> 0; rst_n low while FULL -> res_valid=0 immediately.

Source files
------------

// File: rtl/addsub_rr_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared add/sub
// arbiter and the result consumer.
interface addsub_rr_arbiter_if #(
    parameter int OVF_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_a;
    logic [3:0]       req0_b;
    logic             req0_m;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_a;
    logic [3:0]       req1_b;
    logic             req1_m;
    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [3:0]       res_s;
    logic             res_c;
    logic             res_v;
    logic [OVF_W-1:0] ovf_cnt;
    logic             ovf_clr;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_m,
        input  req1_valid, req1_a, req1_b, req1_m,
        input  res_ready, ovf_clr,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_s, res_c, res_v, ovf_cnt
    );

    // Requester / consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_m,
        output req1_valid, req1_a, req1_b, req1_m,
        output res_ready, ovf_clr,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_s, res_c, res_v, ovf_cnt
    );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Two requesters share one 4-bit add/sub datapath through a round-robin
// (or fixed-priority) arbiter. One-entry result register with valid/ready,
// plus a saturating counter of signed overflows.
module addsub_rr_arbiter #(
    parameter int INIT_PRIO = 0,
    parameter int RR_EN     = 1,
    parameter int OVF_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub_rr_arbiter_if.slave   bus
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_r;
    logic             prio_r;
    logic             res_id_r;
    logic [3:0]       res_s_r;
    logic             res_c_r;
    logic             res_v_r;
    logic [OVF_W-1:0] ovf_cnt_r;

    logic             can_accept_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             gnt_s;
    logic [3:0]       op_a_s;
    logic [3:0]       op_b_s;
    logic             op_m_s;
    logic [3:0]       alu_s_s;
    logic             alu_c_s;
    logic             alu_v_s;

    // The output slot can take a new result when empty or being drained now.
    assign can_accept_s = (state_r == ST_EMPTY) | bus.res_ready;
    assign gnt_s        = gnt0_s | gnt1_s;

    // Pick the winner among valid requesters; prio breaks ties.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (can_accept_s) begin
            case ({bus.req1_valid, bus.req0_valid})
                2'b01:   gnt0_s = 1'b1;
                2'b10:   gnt1_s = 1'b1;
                2'b11: begin
                    if (prio_r) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b1;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Steer the winner's operands onto the shared datapath.
    always_comb begin
        op_a_s = bus.req0_a;
        op_b_s = bus.req0_b;
        op_m_s = bus.req0_m;
        if (gnt1_s) begin
            op_a_s = bus.req1_a;
            op_b_s = bus.req1_b;
            op_m_s = bus.req1_m;
        end else begin
            op_a_s = bus.req0_a;
            op_b_s = bus.req0_b;
            op_m_s = bus.req0_m;
        end
    end

    bit_4_addsub u_addsub (
        .a (op_a_s),
        .b (op_b_s),
        .m (op_m_s),
        .s (alu_s_s),
        .c (alu_c_s),
        .v (alu_v_s)
    );

    // Output-stage FSM and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_EMPTY;
            res_id_r <= 1'b0;
            res_s_r  <= 4'h0;
            res_c_r  <= 1'b0;
            res_v_r  <= 1'b0;
        end else begin
            if (gnt_s) begin
                res_id_r <= gnt1_s;
                res_s_r  <= alu_s_s;
                res_c_r  <= alu_c_s;
                res_v_r  <= alu_v_s;
            end else begin
                res_id_r <= res_id_r;
                res_s_r  <= res_s_r;
                res_c_r  <= res_c_r;
                res_v_r  <= res_v_r;
            end
            case (state_r)
                ST_EMPTY: state_r <= gnt_s ? ST_FULL : ST_EMPTY;
                ST_FULL:  state_r <= (bus.res_ready && !gnt_s) ? ST_EMPTY : ST_FULL;
                default:  state_r <= ST_EMPTY;
            endcase
        end
    end

    // Priority pointer: hand priority to the other requester after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= INIT_PRIO[0];
        end else if ((RR_EN != 0) && gnt_s) begin
            prio_r <= gnt0_s;
        end else begin
            prio_r <= prio_r;
        end
    end

    // Saturating overflow counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_r <= {OVF_W{1'b0}};
        end else if (bus.ovf_clr) begin
            ovf_cnt_r <= {OVF_W{1'b0}};
        end else if (gnt_s && alu_v_s && (ovf_cnt_r != {OVF_W{1'b1}})) begin
            ovf_cnt_r <= ovf_cnt_r + {{(OVF_W-1){1'b0}}, 1'b1};
        end else begin
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    assign bus.req0_ready = gnt0_s;
    assign bus.req1_ready = gnt1_s;
    assign bus.res_valid  = (state_r == ST_FULL);
    assign bus.res_id     = res_id_r;
    assign bus.res_s      = res_s_r;
    assign bus.res_c      = res_c_r;
    assign bus.res_v      = res_v_r;
    assign bus.ovf_cnt    = ovf_cnt_r;
endmodule

// 4-bit adder/subtractor: M=0 -> A+B, M=1 -> A-B (A + ~B + 1).
// C is the raw carry out (1 = no borrow on subtract), V is signed overflow.
module bit_4_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    output logic [3:0] s,
    output logic       c,
    output logic       v
);
    logic [3:0] b_x_s;
    logic [4:0] sum_s;

    assign b_x_s = b ^ {4{m}};
    assign sum_s = {1'b0, a} + {1'b0, b_x_s} + {4'b0000, m};
    assign s     = sum_s[3:0];
    assign c     = sum_s[4];
    assign v     = (a[3] == b_x_s[3]) && (sum_s[3] != a[3]);
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter: add/sub results, round-robin order,
// stall behaviour, edge operands, counter saturation/clear, async reset and
// a fixed-priority instance.
module tb_addsub_rr_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    addsub_rr_arbiter_if #(.OVF_W(2)) bus ();
    addsub_rr_arbiter_if #(.OVF_W(2)) bus_fp ();

    addsub_rr_arbiter #(.INIT_PRIO(0), .RR_EN(1), .OVF_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    addsub_rr_arbiter #(.INIT_PRIO(1), .RR_EN(0), .OVF_W(2)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [7:0] id, input logic [7:0] s,
                             input logic [7:0] c, input logic [7:0] v);
        check_value({tag, "_valid"}, 8'(bus.res_valid), 8'd1);
        check_value({tag, "_id"},    8'(bus.res_id),    id);
        check_value({tag, "_s"},     8'(bus.res_s),     s);
        check_value({tag, "_c"},     8'(bus.res_c),     c);
        check_value({tag, "_v"},     8'(bus.res_v),     v);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = 4'h0; bus.req0_b = 4'h0; bus.req0_m = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = 4'h0; bus.req1_b = 4'h0; bus.req1_m = 1'b0;
        bus.res_ready  = 1'b1; bus.ovf_clr = 1'b0;
        bus_fp.req0_valid = 1'b0; bus_fp.req0_a = 4'h1; bus_fp.req0_b = 4'h1; bus_fp.req0_m = 1'b0;
        bus_fp.req1_valid = 1'b0; bus_fp.req1_a = 4'h3; bus_fp.req1_b = 4'h1; bus_fp.req1_m = 1'b1;
        bus_fp.res_ready  = 1'b1; bus_fp.ovf_clr = 1'b0;

        // Reset state
        repeat (2) tick();
        check_value("rst_res_valid", 8'(bus.res_valid), 8'd0);
        check_value("rst_res_id",    8'(bus.res_id),    8'd0);
        check_value("rst_res_s",     8'(bus.res_s),     8'd0);
        check_value("rst_ovf_cnt",   8'(bus.ovf_cnt),   8'd0);
        rst_n = 1'b1;
        tick();

        // Add: 5+3 on requester 0
        bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd3; bus.req0_m = 1'b0;
        #1;
        check_value("add_req0_ready", 8'(bus.req0_ready), 8'd1);
        check_value("add_req1_ready", 8'(bus.req1_ready), 8'd0);
        tick();
        bus.req0_valid = 1'b0;
        check_res("add", 8'd0, 8'h8, 8'd0, 8'd1);
        check_value("add_ovf_cnt", 8'(bus.ovf_cnt), 8'd1);

        // Sub: 5-3 on requester 1, back-to-back with the previous result
        bus.req1_valid = 1'b1; bus.req1_a = 4'd5; bus.req1_b = 4'd3; bus.req1_m = 1'b1;
        tick();
        bus.req1_valid = 1'b0;
        check_res("sub", 8'd1, 8'h2, 8'd1, 8'd0);
        check_value("sub_ovf_cnt", 8'(bus.ovf_cnt), 8'd1);
        tick();
        check_value("drain_res_valid", 8'(bus.res_valid), 8'd0);

        // Both valid every cycle: grants alternate 0,1,0,1
        bus.req0_valid = 1'b1; bus.req0_a = 4'd1; bus.req0_b = 4'd1; bus.req0_m = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd2; bus.req1_b = 4'd2; bus.req1_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value($sformatf("rr%0d_id", i), 8'(bus.res_id), 8'(i % 2));
            check_value($sformatf("rr%0d_s", i), 8'(bus.res_s), (i % 2 == 0) ? 8'h2 : 8'h0);
            check_value($sformatf("rr%0d_valid", i), 8'(bus.res_valid), 8'd1);
        end

        // Stall three cycles with both requesters valid
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_value($sformatf("stall%0d_r0", i), 8'(bus.req0_ready), 8'd0);
            check_value($sformatf("stall%0d_r1", i), 8'(bus.req1_ready), 8'd0);
            tick();
            check_value($sformatf("stall%0d_id", i), 8'(bus.res_id), 8'd1);
            check_value($sformatf("stall%0d_s", i), 8'(bus.res_s), 8'h0);
            check_value($sformatf("stall%0d_valid", i), 8'(bus.res_valid), 8'd1);
        end
        bus.res_ready = 1'b1;
        #1;
        check_value("release_r0", 8'(bus.req0_ready), 8'd1);
        tick();
        check_value("release_id", 8'(bus.res_id), 8'd0);
        check_value("release_s",  8'(bus.res_s),  8'h2);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // Edge operands
        bus.req0_valid = 1'b1; bus.req0_a = 4'h8; bus.req0_b = 4'h1; bus.req0_m = 1'b1;
        tick();
        check_res("edge_8m1", 8'd0, 8'h7, 8'd1, 8'd1);
        check_value("edge_8m1_ovf", 8'(bus.ovf_cnt), 8'd2);
        bus.req0_a = 4'hF; bus.req0_b = 4'h1; bus.req0_m = 1'b0;
        tick();
        check_res("edge_fp1", 8'd0, 8'h0, 8'd1, 8'd0);
        check_value("edge_fp1_ovf", 8'(bus.ovf_cnt), 8'd2);

        // Saturation: five more overflows on a 2-bit counter
        bus.req0_a = 4'd5; bus.req0_b = 4'd3; bus.req0_m = 1'b0;
        repeat (5) tick();
        check_value("sat_ovf", 8'(bus.ovf_cnt), 8'd3);
        bus.ovf_clr = 1'b1;
        tick();
        check_value("clr_ovf", 8'(bus.ovf_cnt), 8'd0);
        bus.ovf_clr = 1'b0;
        tick();
        check_value("post_clr_ovf", 8'(bus.ovf_cnt), 8'd1);

        // Async reset while FULL
        bus.req0_valid = 1'b0;
        check_value("pre_rst_valid", 8'(bus.res_valid), 8'd1);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_valid", 8'(bus.res_valid), 8'd0);
        check_value("mid_rst_ovf",   8'(bus.ovf_cnt),   8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fixed priority, INIT_PRIO=1: requester 1 always wins
        bus_fp.req0_valid = 1'b1;
        bus_fp.req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_value($sformatf("fp%0d_r0", i), 8'(bus_fp.req0_ready), 8'd0);
            check_value($sformatf("fp%0d_r1", i), 8'(bus_fp.req1_ready), 8'd1);
            tick();
            check_value($sformatf("fp%0d_id", i), 8'(bus_fp.res_id), 8'd1);
            check_value($sformatf("fp%0d_s", i),  8'(bus_fp.res_s),  8'h2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
